// File: rtl/mapper_dispatcher.sv
// mapper_dispatcher: steers a PCIe user stream onto one of NUM_MAPPERS map
// units in round-robin order. The datapath is a zero-latency pass-through;
// only the selected index (curr) and the packet lock are registered.
// In packet mode a packet stays on one mapper from its first beat to its last.
// While no packet is in flight, the selector can optionally step past a
// mapper that is not ready, so one stalled mapper does not hold up the rest.
// Optional build macro MAPPER_DISPATCH_STATS_EN adds one 32-bit dispatch
// counter per mapper (o_dispatch_cnt) and a synchronous clear (i_stats_clr).
module mapper_dispatcher #(
  parameter int NUM_MAPPERS = 4,
  parameter int DATA_WIDTH  = 64,
  parameter int PKT_MODE    = 1,
  parameter int SKIP_BUSY   = 1,
  localparam int SEL_W      = (NUM_MAPPERS > 1) ? $clog2(NUM_MAPPERS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DATA_WIDTH-1:0]     i_pcie_strm_data,
  input  logic                      i_pcie_strm_valid,
  input  logic                      i_pcie_strm_last,
  output logic                      o_pcie_strm_rdy,
  input  logic [NUM_MAPPERS-1:0]    i_mapper_rdy,
  output logic [NUM_MAPPERS-1:0]    o_mapper_valid,
  output logic [DATA_WIDTH-1:0]     o_mapper_data,
  output logic                      o_mapper_last,
`ifdef MAPPER_DISPATCH_STATS_EN
  input  logic                      i_stats_clr,
  output logic [NUM_MAPPERS*32-1:0] o_dispatch_cnt,
`endif
  output logic [SEL_W-1:0]          o_curr_mapper,
  output logic                      o_locked
);

  // Highest legal index; the wrap is an explicit compare so that mapper
  // counts that are not a power of two never reach an unused index.
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_MAPPERS - 1);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [SEL_W-1:0]        curr_reg;
  logic [SEL_W-1:0]        curr_next;
  logic [NUM_MAPPERS-1:0]  sel_onehot;
  logic                    sel_rdy;
  logic                    xfer;
  logic                    pkt_end;

  // One-hot decode of the selected index, one comparator per mapper.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MAPPERS; gi++) begin : g_sel
      assign sel_onehot[gi] = (curr_reg == SEL_W'(gi));
    end
  endgenerate

  // Ready of the selected mapper only; deliberately independent of valid.
  assign sel_rdy = |(sel_onehot & i_mapper_rdy);

  // Pass-through datapath: data and last are broadcast, valid is steered.
  assign o_pcie_strm_rdy = sel_rdy;
  assign o_mapper_data   = i_pcie_strm_data;
  assign o_mapper_last   = i_pcie_strm_last;
  assign o_mapper_valid  = sel_onehot & {NUM_MAPPERS{i_pcie_strm_valid}};

  // An accepted beat, and whether it closes a dispatch unit (every beat in
  // word mode, only the last beat in packet mode).
  assign xfer    = i_pcie_strm_valid & sel_rdy;
  assign pkt_end = (PKT_MODE == 0) || i_pcie_strm_last;

  // Round-robin successor of the current index.
  assign curr_next = (curr_reg == LAST_IDX) ? '0 : curr_reg + SEL_W'(1);

  // Selector and packet-lock state machine.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= UNLOCKED;
      curr_reg  <= '0;
    end else begin
      case (state_reg)
        UNLOCKED: begin
          if (xfer) begin
            if (pkt_end) begin
              curr_reg <= curr_next;
            end else begin
              // First beat of a multi-beat packet: pin the packet here.
              state_reg <= LOCKED;
            end
          end else if ((SKIP_BUSY != 0) && !sel_rdy) begin
            // Idle on a busy mapper: try the next one, one step per cycle.
            curr_reg <= curr_next;
          end
        end
        LOCKED: begin
          // Index frozen until the packet's last beat is accepted, even if
          // the mapper drops ready or upstream drops valid meanwhile.
          if (xfer && i_pcie_strm_last) begin
            state_reg <= UNLOCKED;
            curr_reg  <= curr_next;
          end
        end
        default: begin
          state_reg <= UNLOCKED;
        end
      endcase
    end
  end

  assign o_curr_mapper = curr_reg;
  assign o_locked      = (state_reg == LOCKED);

`ifdef MAPPER_DISPATCH_STATS_EN
  // Per-mapper dispatch counters: beats in word mode, packets in packet mode.
  generate
    for (gi = 0; gi < NUM_MAPPERS; gi++) begin : g_stats
      logic [31:0] cnt_reg;

      // Clear wins over a same-cycle increment; wraps naturally at 2^32.
      always_ff @(posedge i_clk) begin
        if (i_rst || i_stats_clr) begin
          cnt_reg <= '0;
        end else if (xfer && pkt_end && sel_onehot[gi]) begin
          cnt_reg <= cnt_reg + 32'd1;
        end
      end

      assign o_dispatch_cnt[gi*32 +: 32] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_mapper_dispatcher.sv
module tb_mapper_dispatcher;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("PASS %s: 0x%0h", tag, obs);
        end
    endtask

    logic [63:0] w_data, w_mdata;
    logic        w_valid, w_last, w_rdy, w_mlast, w_locked;
    logic [3:0]  w_mrdy, w_mvalid;
    logic [1:0]  w_curr;

    logic [15:0] p_data, p_mdata;
    logic        p_valid, p_last, p_rdy, p_mlast, p_locked;
    logic [2:0]  p_mrdy, p_mvalid;
    logic [1:0]  p_curr;

    logic [15:0] s_data, s_mdata;
    logic        s_valid, s_last, s_rdy, s_mlast, s_locked;
    logic [3:0]  s_mrdy, s_mvalid;
    logic [1:0]  s_curr;

    mapper_dispatcher #(.NUM_MAPPERS(4), .DATA_WIDTH(64), .PKT_MODE(0), .SKIP_BUSY(1)) u_word (
        .i_clk(clk), .i_rst(rst),
        .i_pcie_strm_data(w_data), .i_pcie_strm_valid(w_valid), .i_pcie_strm_last(w_last),
        .o_pcie_strm_rdy(w_rdy), .i_mapper_rdy(w_mrdy), .o_mapper_valid(w_mvalid),
        .o_mapper_data(w_mdata), .o_mapper_last(w_mlast),
`ifdef MAPPER_DISPATCH_STATS_EN
        .i_stats_clr(1'b0), .o_dispatch_cnt(),
`endif
        .o_curr_mapper(w_curr), .o_locked(w_locked)
    );

    mapper_dispatcher #(.NUM_MAPPERS(3), .DATA_WIDTH(16), .PKT_MODE(1), .SKIP_BUSY(0)) u_pkt (
        .i_clk(clk), .i_rst(rst),
        .i_pcie_strm_data(p_data), .i_pcie_strm_valid(p_valid), .i_pcie_strm_last(p_last),
        .o_pcie_strm_rdy(p_rdy), .i_mapper_rdy(p_mrdy), .o_mapper_valid(p_mvalid),
        .o_mapper_data(p_mdata), .o_mapper_last(p_mlast),
`ifdef MAPPER_DISPATCH_STATS_EN
        .i_stats_clr(1'b0), .o_dispatch_cnt(),
`endif
        .o_curr_mapper(p_curr), .o_locked(p_locked)
    );

    mapper_dispatcher #(.NUM_MAPPERS(4), .DATA_WIDTH(16), .PKT_MODE(1), .SKIP_BUSY(1)) u_skip (
        .i_clk(clk), .i_rst(rst),
        .i_pcie_strm_data(s_data), .i_pcie_strm_valid(s_valid), .i_pcie_strm_last(s_last),
        .o_pcie_strm_rdy(s_rdy), .i_mapper_rdy(s_mrdy), .o_mapper_valid(s_mvalid),
        .o_mapper_data(s_mdata), .o_mapper_last(s_mlast),
`ifdef MAPPER_DISPATCH_STATS_EN
        .i_stats_clr(1'b0), .o_dispatch_cnt(),
`endif
        .o_curr_mapper(s_curr), .o_locked(s_locked)
    );

`ifdef MAPPER_DISPATCH_STATS_EN
    logic [15:0] t_data, t_mdata;
    logic        t_valid, t_last, t_rdy, t_mlast, t_locked, t_clr;
    logic [1:0]  t_mrdy, t_mvalid;
    logic [0:0]  t_curr;
    logic [63:0] t_cnt;

    mapper_dispatcher #(.NUM_MAPPERS(2), .DATA_WIDTH(16), .PKT_MODE(1), .SKIP_BUSY(1)) u_stat (
        .i_clk(clk), .i_rst(rst),
        .i_pcie_strm_data(t_data), .i_pcie_strm_valid(t_valid), .i_pcie_strm_last(t_last),
        .o_pcie_strm_rdy(t_rdy), .i_mapper_rdy(t_mrdy), .o_mapper_valid(t_mvalid),
        .o_mapper_data(t_mdata), .o_mapper_last(t_mlast),
        .i_stats_clr(t_clr), .o_dispatch_cnt(t_cnt),
        .o_curr_mapper(t_curr), .o_locked(t_locked)
    );
`endif

    logic [1:0] w_exp_curr [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [3:0] w_exp_oh   [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                   4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic       p_in_last  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [1:0] p_exp_curr [6] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2};
    logic       p_exp_lock [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] p_exp_oh   [6] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b100};
    logic [1:0] s_busy_curr [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    int         t_pkt_len  [5] = '{1, 2, 1, 1, 2};

    initial begin
        rst = 1'b1;
        w_data = '0; w_valid = 1'b0; w_last = 1'b0; w_mrdy = 4'hF;
        p_data = '0; p_valid = 1'b0; p_last = 1'b0; p_mrdy = 3'b111;
        s_data = '0; s_valid = 1'b0; s_last = 1'b0; s_mrdy = 4'hF;
`ifdef MAPPER_DISPATCH_STATS_EN
        t_data = '0; t_valid = 1'b0; t_last = 1'b0; t_mrdy = 2'b11; t_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_w_curr", w_curr, 2'd0);
        check("rst_w_locked", w_locked, 1'b0);
        check("rst_w_mvalid", w_mvalid, 4'b0000);
        check("rst_p_curr", p_curr, 2'd0);
        check("rst_s_curr", s_curr, 2'd0);
        check("rst_s_locked", s_locked, 1'b0);
        w_valid = 1'b1;
        #1;
        check("rst_w_mvalid_bit0", w_mvalid, 4'b0001);
        check("rst_w_rdy", w_rdy, 1'b1);
        w_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            w_valid = 1'b1;
            w_data  = 64'h10 + 64'(i);
            w_last  = (i == 2);
            #1;
            check("word_curr", w_curr, w_exp_curr[i]);
            check("word_mvalid", w_mvalid, w_exp_oh[i]);
            check("word_mdata", w_mdata, 64'h10 + 64'(i));
            check("word_rdy", w_rdy, 1'b1);
            check("word_locked", w_locked, 1'b0);
        end
        @(negedge clk);
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        check("word_wrap_curr", w_curr, 2'd0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            p_valid = 1'b1;
            p_data  = 16'h20 + 16'(i);
            p_last  = p_in_last[i];
            #1;
            check("pkt_curr", p_curr, p_exp_curr[i]);
            check("pkt_locked", p_locked, p_exp_lock[i]);
            check("pkt_mvalid", p_mvalid, p_exp_oh[i]);
            check("pkt_mlast", p_mlast, p_in_last[i]);
            check("pkt_mdata", p_mdata, 16'h20 + 16'(i));
        end
        @(negedge clk);
        p_valid = 1'b0; p_last = 1'b0;
        #1;
        check("pkt_wrap_curr", p_curr, 2'd0);
        check("pkt_end_locked", p_locked, 1'b0);

        p_mrdy = 3'b110;
        @(negedge clk);
        #1;
        check("noskip_curr", p_curr, 2'd0);
        check("noskip_rdy", p_rdy, 1'b0);
        p_valid = 1'b1;
        #1;
        check("noskip_mvalid", p_mvalid, 3'b001);
        @(negedge clk);
        #1;
        check("noskip_curr2", p_curr, 2'd0);
        p_valid = 1'b0; p_mrdy = 3'b111;

        @(negedge clk);
        s_mrdy = 4'b1010;
        #1;
        check("skip_curr0", s_curr, 2'd0);
        check("skip_rdy0", s_rdy, 1'b0);
        @(negedge clk);
        #1;
        check("skip_curr1", s_curr, 2'd1);
        check("skip_rdy1", s_rdy, 1'b1);
        s_valid = 1'b1; s_last = 1'b1; s_data = 16'hA1;
        #1;
        check("skip_mvalid1", s_mvalid, 4'b0010);
        @(negedge clk);
        #1;
        check("skip_curr2", s_curr, 2'd2);
        check("skip_rdy2", s_rdy, 1'b0);
        s_data = 16'hA2;
        #1;
        check("skip_mvalid2", s_mvalid, 4'b0100);
        @(negedge clk);
        #1;
        check("skip_curr3", s_curr, 2'd3);
        check("skip_rdy3", s_rdy, 1'b1);
        check("skip_mvalid3", s_mvalid, 4'b1000);
        check("skip_mdata3", s_mdata, 16'hA2);
        @(negedge clk);
        s_mrdy = 4'b0000;
        #1;
        check("busy_curr0", s_curr, 2'd0);
        check("busy_rdy", s_rdy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            check("busy_curr", s_curr, s_busy_curr[k]);
            check("busy_rdy", s_rdy, 1'b0);
        end
        s_mrdy = 4'hF; s_valid = 1'b0; s_last = 1'b0;

        @(negedge clk);
        s_valid = 1'b1; s_last = 1'b0; s_data = 16'hB0;
        #1;
        check("lock_b0_curr", s_curr, 2'd0);
        check("lock_b0_locked", s_locked, 1'b0);
        check("lock_b0_mvalid", s_mvalid, 4'b0001);
        @(negedge clk);
        s_mrdy = 4'b1110; s_data = 16'hB1;
        #1;
        check("lock_hold_locked", s_locked, 1'b1);
        check("lock_hold_rdy", s_rdy, 1'b0);
        @(negedge clk);
        #1;
        check("lock_hold_curr", s_curr, 2'd0);
        check("lock_hold_locked2", s_locked, 1'b1);
        s_valid = 1'b0;
        #1;
        check("lock_gap_mvalid", s_mvalid, 4'b0000);
        @(negedge clk);
        #1;
        check("lock_gap_curr", s_curr, 2'd0);
        check("lock_gap_locked", s_locked, 1'b1);
        s_mrdy = 4'hF; s_valid = 1'b1;
        #1;
        check("lock_b1_rdy", s_rdy, 1'b1);
        check("lock_b1_mdata", s_mdata, 16'hB1);
        @(negedge clk);
        s_data = 16'hB2;
        #1;
        check("lock_b2_curr", s_curr, 2'd0);
        check("lock_b2_locked", s_locked, 1'b1);
        @(negedge clk);
        s_data = 16'hB3; s_last = 1'b1;
        #1;
        check("lock_b3_mvalid", s_mvalid, 4'b0001);
        check("lock_b3_curr", s_curr, 2'd0);
        @(negedge clk);
        #1;
        check("lock_done_curr", s_curr, 2'd1);
        check("lock_done_locked", s_locked, 1'b0);

        s_data = 16'hC0;
        #1;
        check("rstmid_c0_mvalid", s_mvalid, 4'b0010);
        @(negedge clk);
        s_last = 1'b0; s_data = 16'hC1;
        #1;
        check("rstmid_c1_curr", s_curr, 2'd2);
        check("rstmid_c1_mvalid", s_mvalid, 4'b0100);
        @(negedge clk);
        #1;
        check("rstmid_locked", s_locked, 1'b1);
        check("rstmid_curr", s_curr, 2'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstmid_after_curr", s_curr, 2'd0);
        check("rstmid_after_locked", s_locked, 1'b0);
        check("rstmid_after_bit2", s_mvalid[2], 1'b0);
        check("rstmid_after_mvalid", s_mvalid, 4'b0001);
        s_data = 16'hD0; s_last = 1'b1;
        #1;
        check("rstmid_d0_rdy", s_rdy, 1'b1);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
        #1;
        check("rstmid_d0_next_curr", s_curr, 2'd1);
        check("rstmid_d0_locked", s_locked, 1'b0);

`ifdef MAPPER_DISPATCH_STATS_EN
        check("stats_rst_cnt", t_cnt, 64'h0);
        for (int pk = 0; pk < 5; pk++) begin
            for (int b = 0; b < t_pkt_len[pk]; b++) begin
                @(negedge clk);
                t_valid = 1'b1;
                t_last  = (b == t_pkt_len[pk] - 1);
                t_data  = 16'h300 + 16'(pk * 4 + b);
            end
        end
        @(negedge clk);
        t_valid = 1'b0; t_last = 1'b0;
        #1;
        check("stats_cnt0", t_cnt[31:0], 32'd3);
        check("stats_cnt1", t_cnt[63:32], 32'd2);
        check("stats_curr", t_curr, 1'b1);
        t_valid = 1'b1; t_last = 1'b1; t_clr = 1'b1;
        #1;
        check("stats_clr_mvalid", t_mvalid, 2'b10);
        @(negedge clk);
        t_valid = 1'b0; t_last = 1'b0; t_clr = 1'b0;
        #1;
        check("stats_clr_cnt", t_cnt, 64'h0);
        check("stats_clr_curr", t_curr, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mapper_dispatcher.md
Name: mapper_dispatcher

Overview:
- Next-generation PCIe-stream-to-mapper dispatcher.
- Sits between the PCIe user stream and a bank of NUM_MAPPERS map units, and steers each beat or each packet to one mapper.
- Rotates round-robin, advancing only on accepted transfers.
- Optionally skips mappers that are not ready while no packet is in flight, and keeps packets intact on one mapper in packet mode.

Parameters:
- NUM_MAPPERS, 4: number of mapper channels; legal range 1..16, need not be a power of two.
- DATA_WIDTH, 64: stream data width in bits.
- PKT_MODE, 1: 0 = rotate after every accepted beat; 1 = rotate only after the accepted beat with i_pcie_strm_last=1.
- SKIP_BUSY, 1: 1 = while unlocked, advance past a mapper whose ready is low; 0 = wait on the current mapper.

Ports:
- i_clk  input  1  clock; all logic is rising-edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_pcie_strm_data  input  DATA_WIDTH  upstream data.
- i_pcie_strm_valid  input  1  upstream valid.
- i_pcie_strm_last  input  1  upstream end-of-packet marker.
- o_pcie_strm_rdy  output  1  upstream ready.
- i_mapper_rdy  input  NUM_MAPPERS  per-mapper ready.
- o_mapper_valid  output  NUM_MAPPERS  per-mapper valid; one-hot or zero.
- o_mapper_data  output  DATA_WIDTH  data, broadcast to all mappers.
- o_mapper_last  output  1  last, broadcast to all mappers.
- o_curr_mapper  output  max(1,$clog2(NUM_MAPPERS))  currently selected mapper index.
- o_locked  output  1  high while a packet is mid-transfer (PKT_MODE=1 only).

Behaviour:
- Datapath is combinational pass-through; no added latency:
  - o_mapper_data = i_pcie_strm_data
  - o_mapper_last = i_pcie_strm_last
  - o_pcie_strm_rdy = i_mapper_rdy[curr]
  - o_mapper_valid = one-hot(curr) AND i_pcie_strm_valid; all other bits 0.
- Transfer event xfer = i_pcie_strm_valid & o_pcie_strm_rdy.
- Registers: curr (index), locked (1 bit).
- Reset values: curr=0, locked=0. Outputs therefore reset to o_curr_mapper=0, o_locked=0, o_mapper_valid=0 unless valid is high, in which case only bit 0 follows valid.
- next(curr) = 0 if curr==NUM_MAPPERS-1, else curr+1. Explicit wrap compare; no reliance on power-of-two overflow. Out-of-range indices never occur.
- State UNLOCKED (locked=0):
  - xfer & (PKT_MODE==0 | last): curr<=next(curr); stay UNLOCKED.
  - xfer & PKT_MODE==1 & !last: locked<=1; curr unchanged.
  - no xfer & SKIP_BUSY & !i_mapper_rdy[curr]: curr<=next(curr), one step per cycle, independent of valid.
  - otherwise: hold.
- State LOCKED (locked=1):
  - curr is frozen; no skipping even if the mapper deasserts ready.
  - xfer & last: locked<=0, curr<=next(curr).
  - xfer & !last, or no xfer: hold.
- PKT_MODE=0: locked stays 0 permanently; last is ignored by the control logic.
- Valid may drop mid-packet; the lock persists until last is accepted.
- If all mappers are busy with SKIP_BUSY=1, curr keeps cycling and rdy stays low. No deadlock: the first mapper seen ready accepts.
- NUM_MAPPERS=1: curr is constant 0; the lock still tracks packets.
- Reset mid-packet: curr=0 and locked=0 on the next edge; the partial packet is abandoned and upstream is reset together.
- Ready must not depend on valid: no combinational path from i_pcie_strm_valid to o_pcie_strm_rdy.

Optional Feature:
- Macro: MAPPER_DISPATCH_STATS_EN.
- Defined:
  - Adds output o_dispatch_cnt, NUM_MAPPERS*32 bits: per-mapper 32-bit counters of accepted beats (PKT_MODE=0) or accepted packets, counted on last (PKT_MODE=1).
  - Counters reset to 0 and wrap modulo 2^32.
  - Adds input i_stats_clr: synchronous clear of all counters. Clear has priority over a same-cycle increment.
- Undefined: the port and counters are absent; functional behaviour is identical.

Test Plan:
- Word mode (PKT_MODE=0, N=4, all ready): 8 consecutive valid beats 0x10..0x17 -> mappers 0,1,2,3,0,1,2,3 each receive one beat per cycle; rdy constantly 1.
- Packet mode (N=3): packets of 3,1,2 beats with last on the final beat -> mapper0 gets 3 beats, mapper1 gets 1, mapper2 gets 2; o_locked high only between the first and last beat of the 3- and 2-beat packets; curr then wraps to 0.
- Skip busy (N=4, SKIP_BUSY=1): i_mapper_rdy=4'b1010 and idle from reset -> curr 0->1 in one cycle; a valid beat goes to mapper1, then curr skips 2 and lands on 3 for the next beat.
- Lock holds (PKT_MODE=1): mapper0 drops ready after beat 1 of a 4-beat packet -> curr stays 0, rdy=0, no beats lost or duplicated; the packet completes when ready returns, then curr=1.
- Reset mid-packet: assert i_rst while locked on mapper2 -> next cycle curr=0, locked=0, o_mapper_valid[2]=0; a new packet goes to mapper0.
- Stats (MAPPER_DISPATCH_STATS_EN, PKT_MODE=1, N=2): 5 packets -> counts {3,2}; i_stats_clr pulsed coincident with a last beat -> counts all 0.
